// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP CDC transfer: FSM state encoding and synchroniser depth.
package mcp_pkg;

  typedef enum logic {
    MCP_IDLE  = 1'b0,
    MCP_VALID = 1'b1
  } mcp_state_e;

  localparam int unsigned MCP_SYNC_STAGES = 2;

endpackage

// File: rtl/mcp_tgl_sync.sv
// Toggle synchroniser: SYNC_STAGES flop chain followed by an edge detector that emits
// a one-cycle pulse for every level change of the asynchronous input toggle.
module mcp_tgl_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   tgl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      tgl_d <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], tgl};
      tgl_d <= chain[SYNC_STAGES-1];
    end
  end

  assign pulse = chain[SYNC_STAGES-1] ^ tgl_d;

endmodule

// File: rtl/b_rx_fsm.sv
// Destination half of the MCP CDC transfer: synchronises a_en, captures a_data and offers it
// as valid/ready, toggling b_ack per consumed word. Optional sticky overrun flag: B_RX_OVERRUN_EN.
module b_rx_fsm
  import mcp_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = MCP_SYNC_STAGES
) (
  input  logic          clk_b,
  input  logic          rstn_b,
  input  logic          a_en,
  input  logic [DW-1:0] a_data,
  input  logic          b_ready,
  output logic          b_valid,
  output logic [DW-1:0] b_data,
  output logic          b_ack
`ifdef B_RX_OVERRUN_EN
  ,
  output logic          b_ovr
`endif
);

  mcp_state_e state;
  logic       b_load;

  mcp_tgl_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_en_sync (
    .clk  (clk_b),
    .rst_n(rstn_b),
    .tgl  (a_en),
    .pulse(b_load)
  );

  // a_data is only sampled on b_load in IDLE; a load while VALID is dropped.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      state   <= MCP_IDLE;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_ack   <= 1'b0;
    end else begin
      case (state)
        MCP_IDLE: begin
          if (b_load) begin
            b_data  <= a_data;
            b_valid <= 1'b1;
            state   <= MCP_VALID;
          end
        end
        MCP_VALID: begin
          if (b_ready) begin
            b_ack   <= ~b_ack;
            b_valid <= 1'b0;
            state   <= MCP_IDLE;
          end
        end
        default: begin
          b_valid <= 1'b0;
          state   <= MCP_IDLE;
        end
      endcase
    end
  end

`ifdef B_RX_OVERRUN_EN
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      b_ovr <= 1'b0;
    end else if (b_load && (state == MCP_VALID)) begin
      b_ovr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_b_rx_fsm.sv
// Self-checking bench for b_rx_fsm: directed protocol steps plus randomized async-clock traffic
// from a behavioural source, checked against an in-order word queue.
module tb_b_rx_fsm;

  localparam int unsigned DW = 8;
`ifdef B_RX_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`endif

  logic          clk_b   = 1'b0;
  logic          clk_a   = 1'b0;
  logic          rstn_b  = 1'b0;
  logic          a_en    = 1'b0;
  logic [DW-1:0] a_data  = '0;
  logic          b_ready = 1'b0;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ack;
`ifdef B_RX_OVERRUN_EN
  logic          b_ovr;
`endif

  int          checks   = 0;
  int          errors   = 0;
  int unsigned a_half   = 18;
  int unsigned consumed = 0;

  always #6 clk_b = ~clk_b;
  always #(a_half) clk_a = ~clk_a;

  b_rx_fsm #(
    .DW         (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_b  (clk_b),
    .rstn_b (rstn_b),
    .a_en   (a_en),
    .a_data (a_data),
    .b_ready(b_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ack  (b_ack)
`ifdef B_RX_OVERRUN_EN
    ,
    .b_ovr  (b_ovr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    a_data = d;
    a_en   = ~a_en;
  endtask

  // Source: toggles a_en per word, then waits for the ack toggle through a 2-flop clk_a sync.
  // Sink: random b_ready, each handshake must match the oldest outstanding word.
  task automatic run_random(input int unsigned half, input int n);
    logic [DW-1:0] q[$];
    int            received;
    received = 0;
    a_half   = half;
    fork
      begin
        logic        s1, s2, last;
        int unsigned w;
        s1 = b_ack; s2 = b_ack; last = b_ack;
        for (int i = 0; i < n; i++) begin
          @(posedge clk_a);
          #1;
          a_data = DW'($urandom);
          a_en   = ~a_en;
          q.push_back(a_data);
          w = 0;
          while (s2 == last && w < 2000) begin
            @(posedge clk_a);
            s2 = s1;
            s1 = b_ack;
            w++;
          end
          if (s2 == last) begin
            check("ack_timeout", 32'(w), 32'(0));
            break;
          end
          last = s2;
        end
      end
      begin
        logic          v;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        int unsigned   cyc;
        cyc = 0;
        while (received < n && cyc < 30000) begin
          b_ready = 1'($urandom_range(0, 1));
          v = b_valid;
          d = b_data;
          @(posedge clk_b);
          if (v && b_ready) begin
            consumed++;
            received++;
            if (q.size() == 0) begin
              check("dup_word", 32'(1), 32'(0));
            end else begin
              exp_d = q.pop_front();
              check("order_data", 32'(d), 32'(exp_d));
            end
          end
          #1;
          cyc++;
        end
      end
    join
    b_ready = 1'b0;
    check("rand_count", 32'(received), 32'(n));
    check("rand_leftover", 32'(q.size()), 32'(0));
    step();
    check("rand_ack", 32'(b_ack), 32'(consumed & 1));
    check("rand_valid", 32'(b_valid), 32'(0));
  endtask

  initial begin
    // 1: reset held while a_en toggles
    for (int i = 0; i < 4; i++) begin
      step();
      a_en = ~a_en;
      check("rst_valid", 32'(b_valid), 32'(0));
      check("rst_data", 32'(b_data), 32'(0));
      check("rst_ack", 32'(b_ack), 32'(0));
`ifdef B_RX_OVERRUN_EN
      check("rst_ovr", 32'(b_ovr), 32'(0));
`endif
    end
    a_en   = 1'b0;
    rstn_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_valid", 32'(b_valid), 32'(0));
    end

    // 2: single word with 3-edge latency, then consume
    send(8'hA5);
    step(); check("lat1_valid", 32'(b_valid), 32'(0));
    step(); check("lat2_valid", 32'(b_valid), 32'(0));
    step(); check("lat3_valid", 32'(b_valid), 32'(1));
    check("single_data", 32'(b_data), 32'hA5);
    step(); check("hold_valid", 32'(b_valid), 32'(1));
    b_ready = 1'b1;
    step(); consumed++;
    check("single_consumed", 32'(b_valid), 32'(0));
    check("single_ack", 32'(b_ack), 32'(consumed & 1));

    // 3: ready already high, one-cycle VALID occupancy
    for (int i = 1; i <= 2; i++) begin
      send(8'(i));
      step(); step();
      check("early_pre", 32'(b_valid), 32'(0));
      step();
      check("early_valid", 32'(b_valid), 32'(1));
      check("early_data", 32'(b_data), 32'(i));
      step(); consumed++;
      check("early_gone", 32'(b_valid), 32'(0));
      check("early_ack", 32'(b_ack), 32'(consumed & 1));
    end
    b_ready = 1'b0;

    // 4: overrun while VALID, violating word dropped
    send(8'h3C);
    step(); step(); step();
    check("ovr_valid", 32'(b_valid), 32'(1));
`ifdef B_RX_OVERRUN_EN
    check("ovr_pre", 32'(b_ovr), 32'(0));
`endif
    send(8'hFF);
    for (int i = 0; i < 4; i++) step();
    check("ovr_hold_valid", 32'(b_valid), 32'(1));
    check("ovr_hold_data", 32'(b_data), 32'h3C);
`ifdef B_RX_OVERRUN_EN
    check("ovr_flag", 32'(b_ovr), 32'(OVR_EN));
`endif
    b_ready = 1'b1;
    step(); consumed++;
    b_ready = 1'b0;
    check("ovr_consumed", 32'(b_valid), 32'(0));
    check("ovr_ack", 32'(b_ack), 32'(consumed & 1));
`ifdef B_RX_OVERRUN_EN
    check("ovr_sticky", 32'(b_ovr), 32'(OVR_EN));
`endif
    for (int i = 0; i < 4; i++) step();
    check("ovr_dropped", 32'(b_valid), 32'(0));
    check("ovr_data_kept", 32'(b_data), 32'h3C);

    // 5: asynchronous reset while VALID
    send(8'h5A);
    step(); step(); step();
    check("mid_valid", 32'(b_valid), 32'(1));
    #2;
    rstn_b = 1'b0;
    a_en   = 1'b0;
    consumed = 0;
    #1;
    check("mid_rst_valid", 32'(b_valid), 32'(0));
    check("mid_rst_data", 32'(b_data), 32'(0));
    check("mid_rst_ack", 32'(b_ack), 32'(0));
`ifdef B_RX_OVERRUN_EN
    check("mid_rst_ovr", 32'(b_ovr), 32'(0));
`endif
    step(); step();
    rstn_b = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("mid_after_valid", 32'(b_valid), 32'(0));

    // 6: random traffic at clk_a:clk_b = 3:1 and 1:3 period ratios
    run_random(18, 500);
    run_random(2, 500);
`ifdef B_RX_OVERRUN_EN
    check("rand_ovr", 32'(b_ovr), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
